harvos_imem_slave: RTL and testbench
====================================

HARVOS_IMEM_SLAVE -- requirements
Module: harvos_imem_slave

Interface
REQ-001 SHALL have parameter `WAIT_STATES`, default 0: extra cycles inserted before the memory read; legal range 0..7.
REQ-002 SHALL have parameter `MEM_WORDS`, default 1024: number of 32-bit instruction words backed; a power of two.
REQ-003 SHALL have parameter `BASE_ADDR`, default 32'h0000_0000: byte address of word 0; aligned to 4*`MEM_WORDS`.
REQ-004 SHALL have local constant `AW` = $clog2(`MEM_WORDS`).
REQ-005 SHALL have port `clk`, input, 1 bit: the single clock; all state on rising edge.
REQ-006 SHALL have port `rst_n`, input, 1 bit: reset, asynchronous assert, active-low.
REQ-007 SHALL have port `req`, input, 1 bit: fetch request, held by the master until `rvalid`.
REQ-008 SHALL have port `addr`, input, 32 bits: fetch byte address, stable while `req`=1.
REQ-009 SHALL have port `rdata`, output, 32 bits: instruction word, valid when `rvalid`=1.
REQ-010 SHALL have port `rvalid`, output, 1 bit: one-cycle response strobe.
REQ-011 SHALL have port `fault`, output, 1 bit: asserted with `rvalid` on a rejected fetch.
REQ-012 SHALL have port `mem_en`, output, 1 bit: synchronous-read enable to the backing SRAM/ROM.
REQ-013 SHALL have port `mem_addr`, output, `AW` bits: word index into the backing memory.
REQ-014 SHALL have port `mem_rdata`, input, 32 bits: memory data, valid the cycle after `mem_en`.
REQ-015 SHALL have port `busy`, output, 1 bit: high whenever the FSM is not in IDLE.
REQ-016 Ports `req`/`addr`/`rdata`/`rvalid`/`fault` SHALL map 1:1 onto the slave modport of `harvos_imem_if`.

Function
REQ-017 FSM states SHALL be IDLE, WAIT, READ, RESP.
REQ-018 IDLE with `req`=1: the block SHALL latch `addr` and the fault decision; the next state is RESP if faulting, else WAIT if `WAIT_STATES`>0, else READ.
REQ-019 Fault SHALL be raised when `addr[1:0]`!=0 or when `addr` lies outside [`BASE_ADDR`, `BASE_ADDR`+4*`MEM_WORDS`).
REQ-020 The fault path SHALL not assert `mem_en`.
REQ-021 WAIT SHALL hold for exactly `WAIT_STATES` cycles, counted by a down-counter loaded on accept, then move to READ.
REQ-022 READ SHALL last one cycle with `mem_en`=1 and `mem_addr` = (latched `addr` - `BASE_ADDR`) >> 2, then move to RESP.
REQ-023 RESP SHALL last one cycle with `rvalid`=1 and return to IDLE.
REQ-024 In RESP, `rdata`=`mem_rdata` and `fault`=0 for a good fetch; `rdata`=0 and `fault`=1 for a faulting fetch.
REQ-025 Latency SHALL be `rvalid` at cycle T+2+`WAIT_STATES` for a good fetch and T+1 for a faulting fetch, where T is the accept cycle.
REQ-026 Outside RESP, `rvalid`=0, `fault`=0 and `rdata`=0.
REQ-027 Only one request SHALL be outstanding; `req`/`addr` SHALL be ignored outside IDLE.
REQ-028 A `req` still high in the IDLE cycle after RESP SHALL start a new fetch, giving back-to-back throughput of one fetch per 3+`WAIT_STATES` cycles.
REQ-029 `req` dropping mid-transaction SHALL not abort; the response SHALL still be issued.
REQ-030 Address arithmetic SHALL be unsigned 32-bit; the range upper bound SHALL be compared without overflow, with 33-bit compare width.

Reset
REQ-031 On `rst_n`=0, asynchronously: state=IDLE, counter=0, latched address=0, latched fault=0; `rvalid`=0, `fault`=0, `rdata`=0, `mem_en`=0, `busy`=0.
REQ-032 Reset mid-transaction SHALL discard the fetch with no response.
REQ-033 After reset release, the first rising edge with `req`=1 SHALL be an accept.

Structure
REQ-034 Package `harvos_imem_pkg` SHALL hold the FSM state enum, a `WAIT_STATES` maximum constant of 7, and an instruction-word width constant of 32.
REQ-035 One sub-module, `harvos_imem_range_chk`, SHALL be purely combinational: inputs `addr`, `BASE_ADDR`, `MEM_WORDS`; outputs fault and word index.
REQ-036 The FSM and counter SHALL stay in `harvos_imem_slave`.

Verification
REQ-037 `WAIT_STATES`=0, `addr`=32'h0000_0010, memory word 4 = 32'hDEAD_BEEF -> `mem_en` at T+1 with `mem_addr`=4; `rvalid`=1, `rdata`=32'hDEAD_BEEF, `fault`=0 at T+2.
REQ-038 `WAIT_STATES`=3, same fetch -> `rvalid` at T+5, `busy` high from T+1 to T+5.
REQ-039 `addr`=32'h0000_0012 (misaligned) -> `rvalid`=1, `fault`=1, `rdata`=0 at T+1, `mem_en` never asserted.
REQ-040 `MEM_WORDS`=1024, `addr`=32'h0000_1000 (one past end) -> fault; `addr`=32'h0000_0FFC -> good fetch of word 1023.
REQ-041 `req` held high across 4 fetches with `WAIT_STATES`=0 -> `rvalid` pulses every 3 cycles; changing `addr` in WAIT/READ has no effect on the in-flight fetch.
REQ-042 `rst_n` pulsed low during WAIT -> outputs reset immediately, no `rvalid` follows, and the next `req` is served normally.

Source files
------------

// File: rtl/harvos_imem_pkg.sv
// harvos_imem_pkg: shared FSM state type and sizing constants for the instruction-memory slave
package harvos_imem_pkg;
    localparam int WS_MAX = 7;
    localparam int IW     = 32;
    localparam int CW     = $clog2(WS_MAX + 1);
    typedef enum logic [1:0] {IDLE, WAIT, READ, RESP} state_t;
endpackage

// File: rtl/harvos_imem_range_chk.sv
// harvos_imem_range_chk: combinational alignment/range check and word-index computation
module harvos_imem_range_chk #(
    parameter logic [31:0] BASE_ADDR = 32'h0000_0000,
    parameter int          MEM_WORDS = 1024
) (
    input  logic [31:0]                  i_addr,
    output logic                         o_fault,
    output logic [$clog2(MEM_WORDS)-1:0] o_idx
);
    localparam int AW = $clog2(MEM_WORDS);
    logic [32:0] w_a;
    logic [32:0] w_lo;
    logic [32:0] w_hi;
    // 33-bit bounds so a window ending exactly at 2^32 does not wrap
    assign w_a     = {1'b0, i_addr};
    assign w_lo    = {1'b0, BASE_ADDR};
    assign w_hi    = w_lo + (33'(MEM_WORDS) << 2);
    assign o_fault = (i_addr[1:0] != 2'b00) || (w_a < w_lo) || (w_a >= w_hi);
    assign o_idx   = AW'((i_addr - BASE_ADDR) >> 2);
endmodule

// File: rtl/harvos_imem.sv
// harvos_imem_slave: fetch slave that turns req/addr into one synchronous memory read per request
module harvos_imem_slave
    import harvos_imem_pkg::*;
#(
    parameter int          WAIT_STATES = 0,
    parameter int          MEM_WORDS   = 1024,
    parameter logic [31:0] BASE_ADDR   = 32'h0000_0000
) (
    input  logic                         clk,
    input  logic                         rst_n,
    input  logic                         req,
    input  logic [31:0]                  addr,
    output logic [IW-1:0]                rdata,
    output logic                         rvalid,
    output logic                         fault,
    output logic                         mem_en,
    output logic [$clog2(MEM_WORDS)-1:0] mem_addr,
    input  logic [IW-1:0]                mem_rdata,
    output logic                         busy
);
    localparam int AW = $clog2(MEM_WORDS);
    state_t          r_state;
    state_t          w_next;
    logic [CW-1:0]   r_cnt;
    logic [31:0]     r_addr;
    logic            r_fault;
    logic [31:0]     w_chk_addr;
    logic            w_fault;
    logic [AW-1:0]   w_idx;
    logic            w_accept;
    // One checker serves both the accept decision (live addr) and the read index (latched addr)
    assign w_chk_addr = (r_state == IDLE) ? addr : r_addr;
    assign w_accept   = (r_state == IDLE) && req;
    harvos_imem_range_chk #(
        .BASE_ADDR (BASE_ADDR),
        .MEM_WORDS (MEM_WORDS)
    ) u_chk (
        .i_addr  (w_chk_addr),
        .o_fault (w_fault),
        .o_idx   (w_idx)
    );
    // State register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) r_state <= IDLE;
        else        r_state <= w_next;
    end
    // Latch the request on accept and run the wait-state down-counter
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_cnt   <= '0;
            r_addr  <= '0;
            r_fault <= 1'b0;
        end else if (w_accept) begin
            r_cnt   <= CW'(WAIT_STATES);
            r_addr  <= addr;
            r_fault <= w_fault;
        end else if (r_state == WAIT) begin
            r_cnt   <= r_cnt - 1'b1;
        end
    end
    // Next-state logic; faulting fetches skip the memory entirely
    always_comb begin
        w_next = r_state;
        case (r_state)
            IDLE:    if (req) w_next = w_fault ? RESP : (WAIT_STATES > 0 ? WAIT : READ);
            WAIT:    if (r_cnt <= CW'(1)) w_next = READ;
            READ:    w_next = RESP;
            default: w_next = IDLE;
        endcase
    end
    assign busy     = (r_state != IDLE);
    assign mem_en   = (r_state == READ);
    assign mem_addr = mem_en ? w_idx : '0;
    assign rvalid   = (r_state == RESP);
    assign fault    = rvalid && r_fault;
    assign rdata    = (rvalid && !r_fault) ? mem_rdata : '0;
endmodule

// File: tb/tb_harvos_imem_slave.sv
// tb_harvos_imem_slave: directed checks of the fetch slave with 0 and 3 wait states and a high base address
module tb_harvos_imem_slave;
    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    int          total = 0;
    int          bad = 0;

    logic        req_a = 1'b0, req_b = 1'b0, req_c = 1'b0;
    logic [31:0] addr_a = '0, addr_b = '0, addr_c = '0;
    logic [31:0] rdata_a, rdata_b, rdata_c;
    logic        rvalid_a, rvalid_b, rvalid_c;
    logic        fault_a, fault_b, fault_c;
    logic        men_a, men_b, men_c;
    logic [9:0]  maddr_a, maddr_b, maddr_c;
    logic [31:0] mrd_a = '0, mrd_b = '0, mrd_c = '0;
    logic        busy_a, busy_b, busy_c;

    always #5 clk = ~clk;

    function automatic logic [31:0] memw(input logic [9:0] i);
        return (i == 10'd4) ? 32'hDEAD_BEEF : (32'hA000_0000 | {22'd0, i});
    endfunction

    always @(posedge clk) begin
        if (men_a) mrd_a <= memw(maddr_a);
        if (men_b) mrd_b <= memw(maddr_b);
        if (men_c) mrd_c <= memw(maddr_c);
    end

    harvos_imem_slave #(.WAIT_STATES(0), .MEM_WORDS(1024), .BASE_ADDR(32'h0000_0000)) u_a (
        .clk(clk), .rst_n(rst_n), .req(req_a), .addr(addr_a), .rdata(rdata_a), .rvalid(rvalid_a),
        .fault(fault_a), .mem_en(men_a), .mem_addr(maddr_a), .mem_rdata(mrd_a), .busy(busy_a));
    harvos_imem_slave #(.WAIT_STATES(3), .MEM_WORDS(1024), .BASE_ADDR(32'h0000_0000)) u_b (
        .clk(clk), .rst_n(rst_n), .req(req_b), .addr(addr_b), .rdata(rdata_b), .rvalid(rvalid_b),
        .fault(fault_b), .mem_en(men_b), .mem_addr(maddr_b), .mem_rdata(mrd_b), .busy(busy_b));
    harvos_imem_slave #(.WAIT_STATES(0), .MEM_WORDS(1024), .BASE_ADDR(32'hFFFF_F000)) u_c (
        .clk(clk), .rst_n(rst_n), .req(req_c), .addr(addr_c), .rdata(rdata_c), .rvalid(rvalid_c),
        .fault(fault_c), .mem_en(men_c), .mem_addr(maddr_c), .mem_rdata(mrd_c), .busy(busy_c));

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    logic [31:0] seq_addr[4] = '{32'h0000_0004, 32'h0000_0008, 32'h0000_000C, 32'h0000_0014};
    logic [31:0] seq_data[4] = '{32'hA000_0001, 32'hA000_0002, 32'hA000_0003, 32'hA000_0005};
    logic [9:0]  seq_idx[4]  = '{10'd1, 10'd2, 10'd3, 10'd5};

    initial begin
        step();
        chk("rst_busy_a", 32'(busy_a), 32'd0);
        chk("rst_rvalid_a", 32'(rvalid_a), 32'd0);
        chk("rst_fault_a", 32'(fault_a), 32'd0);
        chk("rst_rdata_a", rdata_a, 32'd0);
        chk("rst_men_a", 32'(men_a), 32'd0);
        chk("rst_busy_b", 32'(busy_b), 32'd0);
        step();
        rst_n = 1'b1;
        step();

        // good fetch, zero wait states
        addr_a = 32'h0000_0010; req_a = 1'b1;
        step();
        chk("ws0_men", 32'(men_a), 32'd1);
        chk("ws0_maddr", 32'(maddr_a), 32'd4);
        chk("ws0_rvalid_early", 32'(rvalid_a), 32'd0);
        step();
        chk("ws0_rvalid", 32'(rvalid_a), 32'd1);
        chk("ws0_rdata", rdata_a, 32'hDEAD_BEEF);
        chk("ws0_fault", 32'(fault_a), 32'd0);
        req_a = 1'b0;
        step();
        chk("ws0_idle_rvalid", 32'(rvalid_a), 32'd0);
        chk("ws0_idle_busy", 32'(busy_a), 32'd0);

        // misaligned fetch faults in one cycle without touching memory
        addr_a = 32'h0000_0012; req_a = 1'b1;
        step();
        chk("mis_rvalid", 32'(rvalid_a), 32'd1);
        chk("mis_fault", 32'(fault_a), 32'd1);
        chk("mis_rdata", rdata_a, 32'd0);
        chk("mis_men", 32'(men_a), 32'd0);
        req_a = 1'b0;
        step();
        chk("mis_after_rvalid", 32'(rvalid_a), 32'd0);
        chk("mis_after_fault", 32'(fault_a), 32'd0);

        // one past the end faults; last word is good
        addr_a = 32'h0000_1000; req_a = 1'b1;
        step();
        chk("end_fault", 32'(fault_a), 32'd1);
        chk("end_rvalid", 32'(rvalid_a), 32'd1);
        chk("end_men", 32'(men_a), 32'd0);
        addr_a = 32'h0000_0FFC;
        step();
        chk("last_idle", 32'(busy_a), 32'd0);
        step();
        chk("last_men", 32'(men_a), 32'd1);
        chk("last_maddr", 32'(maddr_a), 32'd1023);
        req_a = 1'b0;
        step();
        chk("last_rvalid", 32'(rvalid_a), 32'd1);
        chk("last_rdata", rdata_a, 32'hA000_03FF);
        chk("last_fault", 32'(fault_a), 32'd0);
        step();

        // back-to-back with req held; addr scribbled while in flight
        addr_a = seq_addr[0]; req_a = 1'b1;
        for (int i = 0; i < 4; i++) begin
            step();
            chk("b2b_men", 32'(men_a), 32'd1);
            chk("b2b_maddr", 32'(maddr_a), 32'(seq_idx[i]));
            addr_a = 32'h0000_0013;
            step();
            chk("b2b_rvalid", 32'(rvalid_a), 32'd1);
            chk("b2b_rdata", rdata_a, seq_data[i]);
            chk("b2b_fault", 32'(fault_a), 32'd0);
            if (i < 3) addr_a = seq_addr[i + 1];
            else req_a = 1'b0;
            step();
            chk("b2b_gap_rvalid", 32'(rvalid_a), 32'd0);
        end

        // three wait states; req dropped and addr changed mid-flight
        addr_b = 32'h0000_0010; req_b = 1'b1;
        step();
        chk("ws3_busy_t1", 32'(busy_b), 32'd1);
        chk("ws3_men_t1", 32'(men_b), 32'd0);
        req_b = 1'b0; addr_b = 32'h0000_0020;
        step();
        chk("ws3_busy_t2", 32'(busy_b), 32'd1);
        chk("ws3_rvalid_t2", 32'(rvalid_b), 32'd0);
        step();
        chk("ws3_busy_t3", 32'(busy_b), 32'd1);
        chk("ws3_men_t3", 32'(men_b), 32'd0);
        step();
        chk("ws3_men_t4", 32'(men_b), 32'd1);
        chk("ws3_maddr_t4", 32'(maddr_b), 32'd4);
        chk("ws3_rvalid_t4", 32'(rvalid_b), 32'd0);
        step();
        chk("ws3_rvalid_t5", 32'(rvalid_b), 32'd1);
        chk("ws3_rdata_t5", rdata_b, 32'hDEAD_BEEF);
        chk("ws3_busy_t5", 32'(busy_b), 32'd1);
        step();
        chk("ws3_busy_t6", 32'(busy_b), 32'd0);
        chk("ws3_rvalid_t6", 32'(rvalid_b), 32'd0);

        // reset during WAIT discards the fetch
        addr_b = 32'h0000_0010; req_b = 1'b1;
        step();
        chk("rstw_busy", 32'(busy_b), 32'd1);
        req_b = 1'b0;
        rst_n = 1'b0;
        #1;
        chk("rstw_busy_now", 32'(busy_b), 32'd0);
        chk("rstw_rvalid_now", 32'(rvalid_b), 32'd0);
        step();
        rst_n = 1'b1;
        for (int i = 0; i < 6; i++) begin
            step();
            chk("rstw_no_resp", 32'(rvalid_b), 32'd0);
        end
        addr_b = 32'h0000_0008; req_b = 1'b1;
        step();
        chk("rstw_new_busy", 32'(busy_b), 32'd1);
        req_b = 1'b0;
        step();
        step();
        step();
        chk("rstw_new_maddr", 32'(maddr_b), 32'd2);
        step();
        chk("rstw_new_rvalid", 32'(rvalid_b), 32'd1);
        chk("rstw_new_rdata", rdata_b, 32'hA000_0002);

        // window ending at 2^32
        addr_c = 32'hFFFF_FFFC; req_c = 1'b1;
        step();
        chk("hi_men", 32'(men_c), 32'd1);
        chk("hi_maddr", 32'(maddr_c), 32'd1023);
        addr_c = 32'h0000_0000;
        step();
        chk("hi_rvalid", 32'(rvalid_c), 32'd1);
        chk("hi_rdata", rdata_c, 32'hA000_03FF);
        chk("hi_fault", 32'(fault_c), 32'd0);
        step();
        step();
        chk("hi_below_fault", 32'(fault_c), 32'd1);
        chk("hi_below_rdata", rdata_c, 32'd0);
        req_c = 1'b0;
        step();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
